stopwatch_controller: RTL

STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/button_debouncer.sv | 57 +++++
 rtl/stopwatch_controller.sv | 112 +++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared state encodings and button indices for the stopwatch controller.
// No datapath or flow control; definitions only.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_LAP     = 2'b11
    } sw_state_e;

    localparam int BTN_START = 0;
    localparam int BTN_LAP   = 1;
    localparam int BTN_CLEAR = 2;
    localparam int BTN_DIR   = 3;
    localparam int NUM_BTNS  = 4;

    function automatic logic is_active(input sw_state_e s);
        return (s == ST_RUNNING) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-FF synchronizer, debounce filter, registered rise pulse; DEBOUNCE_CYCLES+3 edges raw-to-pulse.
// No backpressure: the press pulse is a single-cycle event.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_dly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter only advances on consecutive mismatches; any match restarts it.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_raw_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            cnt_q       <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM with debounced buttons and tick prescaler; state follows a press pulse by one cycle.
// No backpressure: count_enable and clear are single-cycle pulses the counter stage must take.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int TICK_DIVIDE     = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic       count_enable,
    output logic       up_down,
    output logic       clear,
    output logic       display_hold,
    output logic [1:0] state
);

    localparam int PW = (TICK_DIVIDE > 1) ? $clog2(TICK_DIVIDE) : 1;

    logic [NUM_BTNS-1:0] press;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .btn_raw_i(btn_raw[i]),
            .press_o  (press[i])
        );
    end

    sw_state_e     state_q;
    sw_state_e     state_d;
    logic          up_down_q;
    logic          up_down_d;
    logic          clear_q;
    logic          clear_d;
    logic          count_en_q;
    logic          count_en_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          idle_or_paused;

    assign idle_or_paused = (state_q == ST_IDLE) || (state_q == ST_PAUSED);

    // Priority chain only considers events that are meaningful in the current state.
    always_comb begin
        state_d   = state_q;
        up_down_d = up_down_q;
        clear_d   = 1'b0;
        if (press[BTN_CLEAR] && idle_or_paused) begin
            state_d = ST_IDLE;
            clear_d = 1'b1;
        end else if (press[BTN_START]) begin
            case (state_q)
                ST_IDLE:    state_d = ST_RUNNING;
                ST_RUNNING: state_d = ST_PAUSED;
                ST_PAUSED:  state_d = ST_RUNNING;
                ST_LAP:     state_d = ST_PAUSED;
                default:    state_d = state_q;
            endcase
        end else if (press[BTN_LAP] && is_active(state_q)) begin
            state_d = (state_q == ST_RUNNING) ? ST_LAP : ST_RUNNING;
        end else if (press[BTN_DIR] && idle_or_paused) begin
            up_down_d = ~up_down_q;
        end
    end

    // At the terminal count the prescaler waits rather than wrapping if the FSM is
    // leaving the counting states, so a pause never swallows a due tick.
    always_comb begin
        presc_d    = presc_q;
        count_en_d = 1'b0;
        if (clear_d || (state_q == ST_IDLE && state_d == ST_RUNNING)) begin
            presc_d = '0;
        end else if (is_active(state_q)) begin
            if (presc_q == PW'(TICK_DIVIDE - 1)) begin
                if (is_active(state_d)) begin
                    presc_d    = '0;
                    count_en_d = 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            up_down_q  <= 1'b1;
            clear_q    <= 1'b0;
            count_en_q <= 1'b0;
            presc_q    <= '0;
        end else begin
            state_q    <= state_d;
            up_down_q  <= up_down_d;
            clear_q    <= clear_d;
            count_en_q <= count_en_d;
            presc_q    <= presc_d;
        end
    end

    assign count_enable = count_en_q;
    assign up_down      = up_down_q;
    assign clear        = clear_q;
    assign display_hold = (state_q == ST_LAP);
    assign state        = state_q;

endmodule
